// File: rtl/mem_stage_data_ram_if.sv
// Bus between the EX/MEM pipeline register and the MEM-stage data RAM.
// The master drives the access request; the slave (the RAM) returns data and status.
interface mem_stage_data_ram_if #(
   parameter int ADDR_W = 8
);
   logic              MEM_load_store_instr;
   logic              MEM_ReadWrite;
   logic              MEM_size;
   logic [ADDR_W-1:0] MEM_Address;
   logic [31:0]       MEM_DataIn;
   logic [31:0]       MEM_DataOut;
   logic              MEM_stall;
   logic              MEM_done;
   logic              MEM_misalign;

   modport master (
      output MEM_load_store_instr,
      output MEM_ReadWrite,
      output MEM_size,
      output MEM_Address,
      output MEM_DataIn,
      input  MEM_DataOut,
      input  MEM_stall,
      input  MEM_done,
      input  MEM_misalign
   );

   modport slave (
      input  MEM_load_store_instr,
      input  MEM_ReadWrite,
      input  MEM_size,
      input  MEM_Address,
      input  MEM_DataIn,
      output MEM_DataOut,
      output MEM_stall,
      output MEM_done,
      output MEM_misalign
   );
endinterface

// File: rtl/mem_stage_data_ram.sv
// MEM-stage big-endian byte/word data RAM with fixed wait-state latency and pipeline stall.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned word accesses are flagged, stores dropped, loads return 0.
module mem_stage_data_ram #(
   parameter int LATENCY = 2,
   parameter int ADDR_W  = 8
) (
   input  logic                 Clk,
   input  logic                 Reset,
   mem_stage_data_ram_if.slave  bus
);

   localparam int         DEPTH    = 1 << ADDR_W;
   localparam logic [2:0] CNT_INIT = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_nextState;
   logic [2:0]        r_cnt;
   logic [2:0]        w_nextCnt;
   logic              w_fire;
   logic              w_stall;
   logic              w_accept;

   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_data;
   logic              r_rw;
   logic              r_size;
   logic [31:0]       r_dataOut;
   logic              r_misalign;

   logic [7:0]        r_mem [DEPTH];

   logic [ADDR_W-1:0] w_addr0;
   logic [ADDR_W-1:0] w_addr1;
   logic [ADDR_W-1:0] w_addr2;
   logic [ADDR_W-1:0] w_addr3;
   logic [31:0]       w_wdata;
   logic              w_rw;
   logic              w_size;
   logic              w_misalign;
   logic              w_memWrite;
   logic [31:0]       w_rdWord;

   assign w_accept = (r_state == IDLE) && bus.MEM_load_store_instr;

   // With zero latency the access happens on the accepting edge, so it must use the live request.
   assign w_addr0 = (r_state == IDLE) ? bus.MEM_Address   : r_addr;
   assign w_wdata = (r_state == IDLE) ? bus.MEM_DataIn    : r_data;
   assign w_rw    = (r_state == IDLE) ? bus.MEM_ReadWrite : r_rw;
   assign w_size  = (r_state == IDLE) ? bus.MEM_size      : r_size;

   assign w_addr1 = w_addr0 + ADDR_W'(1);
   assign w_addr2 = w_addr0 + ADDR_W'(2);
   assign w_addr3 = w_addr0 + ADDR_W'(3);

`ifdef MEM_ALIGN_CHECK_EN
   assign w_misalign = w_size && (w_addr0[1:0] != 2'b00);
`else
   assign w_misalign = 1'b0;
`endif

   assign w_memWrite = w_fire && w_rw && !w_misalign;
   assign w_rdWord   = {r_mem[w_addr0], r_mem[w_addr1], r_mem[w_addr2], r_mem[w_addr3]};

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= IDLE;
         r_cnt   <= 3'd0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_fire      = 1'b0;
      w_stall     = 1'b0;
      case (r_state)
         IDLE: begin
            w_stall = bus.MEM_load_store_instr;
            if (bus.MEM_load_store_instr) begin
               if (LATENCY == 0) begin
                  w_fire      = 1'b1;
                  w_nextState = DONE;
               end else begin
                  w_nextCnt   = CNT_INIT;
                  w_nextState = WAIT;
               end
            end
         end
         WAIT: begin
            w_stall = 1'b1;
            if (r_cnt == 3'd0) begin
               w_fire      = 1'b1;
               w_nextState = DONE;
            end else begin
               w_nextCnt = r_cnt - 3'd1;
            end
         end
         DONE: begin
            // The request is still asserted here by the same instruction; ignore it.
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_addr <= '0;
         r_data <= 32'd0;
         r_rw   <= 1'b0;
         r_size <= 1'b0;
      end else if (w_accept) begin
         r_addr <= bus.MEM_Address;
         r_data <= bus.MEM_DataIn;
         r_rw   <= bus.MEM_ReadWrite;
         r_size <= bus.MEM_size;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_dataOut  <= 32'd0;
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= w_fire && w_misalign;
         if (w_fire && !w_rw) begin
            if (w_misalign) begin
               r_dataOut <= 32'd0;
            end else if (w_size) begin
               r_dataOut <= w_rdWord;
            end else begin
               r_dataOut <= {24'd0, r_mem[w_addr0]};
            end
         end
      end
   end

   // Storage is deliberately not reset; reset only aborts accesses before they fire.
   always_ff @(posedge Clk) begin
      if (w_memWrite) begin
         if (w_size) begin
            r_mem[w_addr0] <= w_wdata[31:24];
            r_mem[w_addr1] <= w_wdata[23:16];
            r_mem[w_addr2] <= w_wdata[15:8];
            r_mem[w_addr3] <= w_wdata[7:0];
         end else begin
            r_mem[w_addr0] <= w_wdata[7:0];
         end
      end
   end

   assign bus.MEM_DataOut  = r_dataOut;
   assign bus.MEM_stall    = w_stall;
   assign bus.MEM_done     = (r_state == DONE);
   assign bus.MEM_misalign = r_misalign;

endmodule
